// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: opcode encoding and its width.
package program_sequencer_pkg;

   localparam int unsigned OP_W = 3;

   // Encodings 6 and 7 are reserved and decode as NOP.
   typedef enum logic [OP_W-1:0] {
      OpNop      = 3'd0,
      OpInc      = 3'd1,
      OpJump     = 3'd2,
      OpJumpCond = 3'd3,
      OpCall     = 3'd4,
      OpRet      = 3'd5
   } op_e;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program sequencer.
// The write pointer wraps modulo DEPTH, so a push while full overwrites the oldest
// entry and keeps the depth saturated at DEPTH. Storage itself is never reset.
module pc_return_stack #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_top,
   output logic [$clog2(DEPTH):0]   o_depth,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W:0]   r_depth;
   logic [PTR_W-1:0] w_ptr_dec;
   logic             w_full;
   logic             w_empty;

   assign w_ptr_dec = r_ptr - PTR_W'(1);
   assign w_full    = (r_depth == (PTR_W+1)'(DEPTH));
   assign w_empty   = (r_depth == '0);

   // Pointer and depth bookkeeping; a pop on an empty stack is ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr   <= '0;
         r_depth <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + PTR_W'(1);
         if (!w_full) begin
            r_depth <= r_depth + (PTR_W+1)'(1);
         end
      end else if (i_pop && !w_empty) begin
         r_ptr   <= w_ptr_dec;
         r_depth <= r_depth - (PTR_W+1)'(1);
      end
   end

   // Entry write; contents are only consumed when the stack is non-empty.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_ptr] <= i_data;
      end
   end

   assign o_top   = r_mem[w_ptr_dec];
   assign o_depth = r_depth;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/program_sequencer.sv
// Program-counter sequencer with NOP/INC/JUMP/JUMP_COND/CALL/RET and a return stack.
// Optional macro PROGRAM_SEQUENCER_STACK_CHECK_EN: stack overflow/underflow become
// faults that block the operation and set a sticky o_error. Without it, overflow
// overwrites the oldest entry and RET on an empty stack behaves as INC.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned RESET_ADDR = 0
) (
   input  logic                     mclk,
   input  logic                     i_rst_n,
   input  logic                     mclk_en,
   input  logic                     i_halt,
   input  logic [OP_W-1:0]          i_op,
   input  logic                     i_cond,
   input  logic [WIDTH-1:0]         i_load_data,
   input  logic                     i_err_clr,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_depth,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_error
);

   logic [1:0]       r_rst_sync;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_d;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_top;
   logic             w_upd;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   op_e              w_op;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
   logic             w_fault;
   logic             r_error;
`else
   logic             w_unused_err_clr;
`endif

   assign w_op     = op_e'(i_op);
   assign w_pc_inc = r_pc + WIDTH'(1);
   assign w_upd    = mclk_en & ~i_halt & r_rst_sync[1];

   // Reset release synchroniser: updates resume only once the release has passed two flops.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   // Operation decode: next PC, stack push/pop and fault detection.
   always_comb begin
      w_pc_d = r_pc;
      w_push = 1'b0;
      w_pop  = 1'b0;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      w_fault = 1'b0;
`endif
      if (w_upd) begin
         case (w_op)
            OpInc:      w_pc_d = w_pc_inc;
            OpJump:     w_pc_d = i_load_data;
            OpJumpCond: w_pc_d = i_cond ? i_load_data : w_pc_inc;
            OpCall: begin
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
               if (w_full) begin
                  w_fault = 1'b1;
               end else begin
                  w_push = 1'b1;
                  w_pc_d = i_load_data;
               end
`else
               w_push = 1'b1;
               w_pc_d = i_load_data;
`endif
            end
            OpRet: begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_pc_d = w_top;
               end else begin
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
                  w_fault = 1'b1;
`else
                  w_pc_d = w_pc_inc;
`endif
               end
            end
            default:    w_pc_d = r_pc;
         endcase
      end
   end

   // Program counter register.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= WIDTH'(RESET_ADDR);
      end else begin
         r_pc <= w_pc_d;
      end
   end

`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
   // Sticky fault flag; a fault in the same cycle as a clear keeps it set.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_error <= 1'b0;
      end else if (w_fault) begin
         r_error <= 1'b1;
      end else if (i_err_clr) begin
         r_error <= 1'b0;
      end
   end
   assign o_error = r_error;
`else
   assign w_unused_err_clr = i_err_clr;
   assign o_error          = 1'b0;
`endif

   pc_return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .i_clk   (mclk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_top),
      .o_depth (o_depth),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_data  = r_pc;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer (WIDTH=4, DEPTH=4, RESET_ADDR=0).
// Stimulus pushes hand-computed expectations; a monitor on the falling edge pops and compares.
module tb_program_sequencer;

   localparam logic [2:0] NOP = 3'd0, INC = 3'd1, JMP = 3'd2, JC = 3'd3, CALL = 3'd4,
                          RET = 3'd5;

   typedef struct {
      string      name;
      logic [3:0] pc;
      logic [2:0] dep;
      bit         err;
   } exp_t;

   logic       mclk = 1'b0;
   logic       i_rst_n;
   logic       mclk_en;
   logic       i_halt;
   logic [2:0] i_op;
   logic       i_cond;
   logic [3:0] i_load_data;
   logic       i_err_clr;
   logic [3:0] o_data;
   logic [2:0] o_depth;
   logic       o_full;
   logic       o_empty;
   logic       o_error;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   program_sequencer #(
      .WIDTH      (4),
      .DEPTH      (4),
      .RESET_ADDR (0)
   ) dut (
      .mclk        (mclk),
      .i_rst_n     (i_rst_n),
      .mclk_en     (mclk_en),
      .i_halt      (i_halt),
      .i_op        (i_op),
      .i_cond      (i_cond),
      .i_load_data (i_load_data),
      .i_err_clr   (i_err_clr),
      .o_data      (o_data),
      .o_depth     (o_depth),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_error     (o_error)
   );

   always #5 mclk = ~mclk;

   // Monitor: one expectation is consumed per falling edge.
   initial begin
      exp_t e;
      logic exp_full;
      logic exp_empty;
      forever begin
         @(negedge mclk);
         if (q.size() > 0) begin
            e         = q.pop_front();
            exp_full  = (e.dep == 3'd4);
            exp_empty = (e.dep == 3'd0);
            total++;
            if (o_data !== e.pc || o_depth !== e.dep || o_full !== exp_full ||
                o_empty !== exp_empty || o_error !== e.err) begin
               bad++;
               $display("FAIL %s: got pc=%0d depth=%0d full=%0b empty=%0b err=%0b, want pc=%0d depth=%0d full=%0b empty=%0b err=%0b",
                        e.name, o_data, o_depth, o_full, o_empty, o_error,
                        e.pc, e.dep, exp_full, exp_empty, e.err);
            end
         end
      end
   end

   // Drive one operation, record its expected result, advance to just after the next falling edge.
   task automatic step(input logic [2:0] op, input logic [3:0] ld, input bit cond,
                       input bit en, input bit halt, input bit clr,
                       input logic [3:0] epc, input logic [2:0] edep, input bit eerr,
                       input string name);
      exp_t e;
      i_op        = op;
      i_load_data = ld;
      i_cond      = cond;
      mclk_en     = en;
      i_halt      = halt;
      i_err_clr   = clr;
      e.name = name; e.pc = epc; e.dep = edep; e.err = eerr;
      q.push_back(e);
      @(negedge mclk);
      #1;
   endtask

   task automatic op1(input logic [2:0] op, input logic [3:0] ld,
                      input logic [3:0] epc, input logic [2:0] edep, input bit eerr,
                      input string name);
      step(op, ld, 1'b0, 1'b1, 1'b0, 1'b0, epc, edep, eerr, name);
   endtask

   // Short reset pulse between edges with INC pending; the following edge must not update.
   task automatic reset_pulse(input string name);
      exp_t e;
      i_op = INC; mclk_en = 1'b1; i_halt = 1'b0; i_err_clr = 1'b0;
      i_rst_n = 1'b0;
      e.name = name; e.pc = 4'd0; e.dep = 3'd0; e.err = 1'b0;
      q.push_back(e);
      #2;
      i_rst_n = 1'b1;
      @(negedge mclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; mclk_en = 1'b1; i_halt = 1'b0; i_op = NOP;
      i_cond = 1'b0; i_load_data = '0; i_err_clr = 1'b0;
      @(negedge mclk);
      #1;
      op1(INC, 0, 0, 0, 0, "reset_hold");
      i_rst_n = 1'b1;
      op1(INC, 0, 0, 0, 0, "sync_edge1");
      op1(NOP, 0, 0, 0, 0, "sync_edge2");

      for (int k = 0; k < 18; k++) begin
         op1(INC, 0, 4'((k + 1) % 16), 0, 0, "inc_wrap");
      end

      op1(JC, 7, 3, 0, 0, "jc_false");
      op1(JMP, 2, 2, 0, 0, "jump");
      step(JC, 7, 1, 1, 0, 0, 7, 0, 0, "jc_true");
      op1(JMP, 2, 2, 0, 0, "jump2");
      step(JC, 7, 1, 1, 1, 0, 2, 0, 0, "jc_halt");
      step(JC, 7, 1, 0, 0, 0, 2, 0, 0, "jc_noen");

      op1(JMP, 3, 3, 0, 0, "jump3");
      op1(CALL, 9, 9, 1, 0, "call");
      step(CALL, 5, 0, 1, 1, 0, 9, 1, 0, "call_halt");
      op1(RET, 0, 4, 0, 0, "ret");
      op1(3'd6, 11, 4, 0, 0, "op6_nop");
      op1(3'd7, 11, 4, 0, 0, "op7_nop");

`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      op1(RET, 0, 4, 0, 1, "ret_empty_fault");
      step(NOP, 0, 0, 1, 1, 1, 4, 0, 0, "err_clr_halt");
`else
      op1(RET, 0, 5, 0, 0, "ret_empty_inc");
`endif

      op1(JMP, 0, 0, 0, 0, "jump0");
      op1(CALL, 4, 4, 1, 0, "call1");
      op1(CALL, 8, 8, 2, 0, "call2");
      op1(CALL, 12, 12, 3, 0, "call3");
      op1(CALL, 10, 10, 4, 0, "call4_full");
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      op1(CALL, 6, 10, 4, 1, "call5_fault");
      step(NOP, 0, 0, 1, 0, 1, 10, 4, 0, "err_clr");
      op1(RET, 0, 13, 3, 0, "ret_lifo1");
      op1(RET, 0, 9, 2, 0, "ret_lifo2");
      op1(RET, 0, 5, 1, 0, "ret_lifo3");
      op1(RET, 0, 1, 0, 0, "ret_lifo4");
      step(RET, 0, 0, 1, 0, 1, 1, 0, 1, "fault_wins_clr");
      step(NOP, 0, 0, 1, 0, 1, 1, 0, 0, "err_clr2");
      op1(CALL, 3, 3, 1, 0, "nest1");
`else
      op1(CALL, 6, 6, 4, 0, "call5_overwrite");
      op1(RET, 0, 11, 3, 0, "ret_lifo1");
      op1(RET, 0, 13, 2, 0, "ret_lifo2");
      op1(RET, 0, 9, 1, 0, "ret_lifo3");
      op1(RET, 0, 5, 0, 0, "ret_lifo4");
      op1(CALL, 3, 3, 1, 0, "nest1");
`endif
      op1(CALL, 7, 7, 2, 0, "nest2");
      reset_pulse("reset_mid_call");
      op1(NOP, 0, 0, 0, 0, "post_reset");
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      op1(RET, 0, 0, 0, 1, "ret_after_reset");
`else
      op1(RET, 0, 1, 0, 0, "ret_after_reset");
`endif

      @(negedge mclk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
